alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Round-robin arbiter and sequencer sharing one combinational ALU (5-bit ctrl, ZHI/ZLO outputs) between two requesters.
//  - Latches the granted request's operands and opcode, then holds the ALU inputs stable for the operation latency.
//  - Captures ZHI/ZLO into result registers and returns them on a valid/ready response channel tagged with the requester id.
//  - Sits between the datapath control units and the shared ALU instance.
// PARAMETERS
//  DATA_W         32  operand/result width
//  MULDIV_CYCLES   4  EXEC cycles for mul (00010) and div (00011); legal range 1..15
//  SIMPLE_CYCLES   1  EXEC cycles for all other legal ops; legal range 1..15
// PORTS
//  clk        in   1         clock; all state updates on the rising edge
//  clr        in   1         reset; synchronous, active-high
//  req_valid  in   2         per-requester request valid; bit i = requester i
//  req_ready  out  2         per-requester accept; a handshake completes on valid&ready
//  req_op     in   10        opcodes; [4:0] = req0, [9:5] = req1
//  req_a      in   2*DATA_W  operand A; [DATA_W-1:0] = req0
//  req_b      in   2*DATA_W  operand B; same packing as req_a
//  alu_a      out  DATA_W    registered operand A to the ALU
//  alu_b      out  DATA_W    registered operand B to the ALU
//  alu_ctrl   out  5         registered ALU opcode
//  alu_enable out  1         high in EXEC only
//  alu_zhi    in   DATA_W    ALU high result (remainder / product upper half)
//  alu_zlo    in   DATA_W    ALU low result
//  rsp_valid  out  1         result valid
//  rsp_ready  in   1         consumer accepts the result
//  rsp_id     out  1         id of the requester that owns the result
//  rsp_hi     out  DATA_W    captured ZHI
//  rsp_lo     out  DATA_W    captured ZLO
//  rsp_err    out  1         illegal opcode, or divide-by-zero (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output is 0 (including req_ready), FSM=IDLE, cnt=0, last_grant=1 so req0 wins the first tie.
//  FSM: IDLE -> EXEC -> CAPT -> RESP -> IDLE. One operation is in flight at a time; there is no queueing.
//  IDLE
//   - req_ready is combinational and is one-hot for the winner only; req_ready=0 in every other state.
//   - Winner when both are valid: !last_grant. Otherwise the single valid requester wins.
//   - On the handshake: latch a/b/op into alu_a/alu_b/alu_ctrl, store the id, set last_grant=id.
//   - Legal op (00000..01011): go to EXEC with cnt = MULDIV_CYCLES or SIMPLE_CYCLES, as the op requires.
//   - Illegal op (01100..11111): skip the ALU; rsp_hi=rsp_lo=0, rsp_err=1, go straight to RESP.
//  EXEC
//   - alu_enable=1; alu_a/alu_b/alu_ctrl are held constant.
//   - Decrement cnt each cycle; when cnt==1, go to CAPT.
//  CAPT
//   - Register alu_zhi/alu_zlo into rsp_hi/rsp_lo; alu_enable=0; go to RESP.
//  RESP
//   - rsp_valid=1; rsp_* are stable until rsp_valid&rsp_ready.
//   - On the response handshake: return to IDLE and drop rsp_valid.
//  Latency:
//   - Request handshake to rsp_valid = cycles+2: SIMPLE 3, MULDIV 6 at defaults.
//   - Illegal op: rsp_valid 1 cycle after the handshake.
//  Next grant: earliest is the cycle after the response handshake. Back-to-back ops cost one IDLE cycle.
//  Requests arriving during a busy period are not lost; they wait with req_ready=0.
//  req_valid must hold until its handshake; the block does not check this.
//  Widths: the ALU defines all arithmetic; this block never modifies the captured results.
//  clr mid-operation: abort on that edge, return to reset state, drop any pending response.
//  clr has priority over every other event, including a simultaneous handshake.
// CONFIGURATION
//  DIV0_TRAP_EN
//   - Defined: div (00011) with B==0 skips EXEC/CAPT; rsp_hi=rsp_lo=0, rsp_err=1, rsp_valid 1 cycle after the handshake.
//   - Undefined: div by zero runs normally; captured ALU outputs pass through unchanged, rsp_err=0.
// TESTING
//  1. clr high 2 cycles: all outputs 0. req0 add a=5,b=7: rsp_valid at +3, lo=12, hi=0, id=0, err=0.
//  2. Both valid in IDLE after reset: req0 granted first (sub 10-3 -> lo=7). req1 granted next (or 0xF0|0x0F -> lo=0xFF, id=1).
//  3. req1 mul a=0x10000,b=0x10000: rsp_valid at +6, hi=1, lo=0. Hold rsp_ready=0 5 cycles: rsp_* stable, req_ready=0.
//  4. req0 div 17/5: lo=3, hi=2. Div 9/0 with DIV0_TRAP_EN: err=1, lo=hi=0 at +1. Without it: err=0.
//  5. op=5'b11111: rsp_err=1, lo=hi=0 at +1; alu_enable never asserted.
//  6. clr asserted in EXEC of a mul: next cycle IDLE, rsp_valid=0. A following add 1+1 returns lo=2 with no stale data.

Source files
------------

// File: rtl/alu_sequencer.sv
// Round-robin arbiter/sequencer that shares one combinational ALU between two requesters.
// Optional feature: define DIV0_TRAP_EN to trap divide-by-zero without running the ALU.
module alu_sequencer #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned SIMPLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [9:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [4:0]            alu_ctrl,
  output logic                  alu_enable,
  input  logic [DATA_W-1:0]     alu_zhi,
  input  logic [DATA_W-1:0]     alu_zlo,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_hi,
  output logic [DATA_W-1:0]     rsp_lo,
  output logic                  rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_LAST = 5'b01011;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              last_grant;
  logic              id_q;

  logic              grant_id;
  logic              handshake;
  logic [4:0]        op_sel;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic              illegal;
  logic              trap;

  // Grant selection: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant_id  = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req_valid[1];
    end
    if (state == S_IDLE && !clr && req_valid != 2'b00) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
    handshake = |(req_ready & req_valid);
    op_sel    = grant_id ? req_op[9:5] : req_op[4:0];
    a_sel     = grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    b_sel     = grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    illegal   = (op_sel > OP_LAST);
`ifdef DIV0_TRAP_EN
    trap      = (op_sel == OP_DIV) && (b_sel == '0);
`else
    trap      = 1'b0;
`endif
  end

  assign alu_enable = (state == S_EXEC);
  assign rsp_valid  = (state == S_RESP);
  assign rsp_id     = id_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 5'd0;
      rsp_hi     <= '0;
      rsp_lo     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (handshake) begin
            alu_a      <= a_sel;
            alu_b      <= b_sel;
            alu_ctrl   <= op_sel;
            id_q       <= grant_id;
            last_grant <= grant_id;
            // Rejected ops never touch the ALU and answer on the next cycle.
            if (illegal || trap) begin
              rsp_hi  <= '0;
              rsp_lo  <= '0;
              rsp_err <= 1'b1;
              cnt     <= 4'd0;
              state   <= S_RESP;
            end else begin
              rsp_err <= 1'b0;
              cnt     <= (op_sel == OP_MUL || op_sel == OP_DIV) ?
                         4'(MULDIV_CYCLES) : 4'(SIMPLE_CYCLES);
              state   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_CAPT;
          end
        end
        S_CAPT: begin
          rsp_hi <= alu_zhi;
          rsp_lo <= alu_zlo;
          state  <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and request/response model.
// Honours DIV0_TRAP_EN the same way as the design build.
module tb_alu_sequencer;

  localparam int DW = 32;
  localparam int MULDIV_N = 4;
  localparam int SIMPLE_N = 1;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd5;

  logic            clk = 1'b0;
  logic            clr;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [9:0]      req_op;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [4:0]      alu_ctrl;
  logic            alu_enable;
  logic [DW-1:0]   alu_zhi;
  logic [DW-1:0]   alu_zlo;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [DW-1:0]   rsp_hi;
  logic [DW-1:0]   rsp_lo;
  logic            rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending requests and who won the last grant.
  logic        lg_m;
  bit          pend [2];
  logic [4:0]  p_op [2];
  logic [31:0] p_a  [2];
  logic [31:0] p_b  [2];

  always #5 clk = ~clk;

  // Behavioural shared ALU: returns {hi, lo}.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    case (op)
      5'd0:  return {32'd0, a + b};
      5'd1:  return {32'd0, a - b};
      5'd2:  begin p = {32'd0, a} * {32'd0, b}; return p; end
      5'd3:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      5'd4:  return {32'd0, a & b};
      5'd5:  return {32'd0, a | b};
      5'd6:  return {32'd0, a ^ b};
      5'd7:  return {32'd0, ~(a | b)};
      5'd8:  return {32'd0, 31'd0, ($signed(a) < $signed(b))};
      5'd9:  return {32'd0, a << b[4:0]};
      5'd10: return {32'd0, a >> b[4:0]};
      5'd11: return {32'd0, $unsigned($signed(a) >>> b[4:0])};
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  assign {alu_zhi, alu_zlo} = alu_fn(alu_ctrl, alu_a, alu_b);

  alu_sequencer #(.DATA_W(DW), .MULDIV_CYCLES(MULDIV_N), .SIMPLE_CYCLES(SIMPLE_N)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_enable(alu_enable),
    .alu_zhi(alu_zhi), .alu_zlo(alu_zlo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected response for one operation, derived from the opcode rules.
  task automatic expectResult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo,
                              output logic err, output int lat, output int en);
    bit rejected;
    int n;
    rejected = (op > 5'd11);
`ifdef DIV0_TRAP_EN
    if (op == OP_DIV && b == 0) rejected = 1'b1;
`endif
    if (rejected) begin
      hi = 0; lo = 0; err = 1'b1; lat = 1; en = 0;
    end else begin
      {hi, lo} = alu_fn(op, a, b);
      err = 1'b0;
      n   = (op == OP_MUL || op == OP_DIV) ? MULDIV_N : SIMPLE_N;
      lat = n + 2;
      en  = n;
    end
  endtask

  task automatic applyStimulus(input int id, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    p_op[id] = op; p_a[id] = a; p_b[id] = b; pend[id] = 1'b1;
    req_op[id*5 +: 5]  = op;
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_valid[id]      = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    clr = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; lg_m = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  // Drives one granted transaction to completion and checks grant, latency, ALU use and response.
  task automatic runTransaction(input int hold);
    int id, cyc, en, bad, busy, hold_bad, exp_lat, exp_en;
    logic [31:0] e_hi, e_lo;
    logic e_err;
    #1;
    if (pend[0] && pend[1]) id = (lg_m == 1'b1) ? 0 : 1;
    else id = pend[1] ? 1 : 0;
    cyc = 0;
    while (req_ready == 2'b00 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    checkOutput("req_ready_grant", 64'(req_ready), (id == 1) ? 64'd2 : 64'd1);
    expectResult(p_op[id], p_a[id], p_b[id], e_hi, e_lo, e_err, exp_lat, exp_en);
    @(negedge clk);
    req_valid[id] = 1'b0; pend[id] = 1'b0; lg_m = id[0];
    #1;
    cyc = 1; en = 0; bad = 0; busy = 0;
    while (!rsp_valid && cyc < 60) begin
      if (alu_enable) begin
        en++;
        if (alu_a !== p_a[id] || alu_b !== p_b[id] || alu_ctrl !== p_op[id]) bad++;
      end
      if (req_ready !== 2'b00) busy++;
      @(negedge clk); cyc++;
    end
    checkOutput("latency", 64'(cyc), 64'(exp_lat));
    checkOutput("alu_enable_cycles", 64'(en), 64'(exp_en));
    checkOutput("alu_inputs_unstable", 64'(bad), 64'd0);
    checkOutput("ready_while_busy", 64'(busy), 64'd0);
    checkOutput("rsp_id", 64'(rsp_id), 64'(id));
    checkOutput("rsp_err", 64'(rsp_err), 64'(e_err));
    checkOutput("rsp_hi", 64'(rsp_hi), 64'(e_hi));
    checkOutput("rsp_lo", 64'(rsp_lo), 64'(e_lo));
    if (hold > 0) begin
      hold_bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_hi !== e_hi || rsp_lo !== e_lo || rsp_err !== e_err ||
            rsp_id !== id[0] || req_ready !== 2'b00) hold_bad++;
      end
      checkOutput("rsp_hold_stable", 64'(hold_bad), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] b;
    int mask;
    clr = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0; lg_m = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_alu", {alu_a, 27'(alu_ctrl), alu_enable}, 64'd0);
    checkOutput("reset_alu_b", 64'(alu_b), 64'd0);
    checkOutput("reset_rsp", {30'(rsp_hi), rsp_valid, rsp_id, rsp_lo}, 64'd0);
    checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
    req_valid = 2'b01;
    #1;
    checkOutput("clr_blocks_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    clr = 1'b0;

    // Simple add, then a held mul from req1 while req0 waits.
    applyStimulus(0, OP_ADD, 32'd5, 32'd7);
    runTransaction(0);
    applyStimulus(1, OP_MUL, 32'h10000, 32'h10000);
    applyStimulus(0, OP_ADD, 32'd1, 32'd2);
    runTransaction(5);
    runTransaction(0);

    // Tie straight after reset goes to req0, then req1.
    doReset();
    applyStimulus(0, OP_SUB, 32'd10, 32'd3);
    applyStimulus(1, OP_OR, 32'hF0, 32'h0F);
    runTransaction(0);
    runTransaction(0);

    applyStimulus(0, OP_DIV, 32'd17, 32'd5);
    runTransaction(0);
    applyStimulus(0, OP_DIV, 32'd9, 32'd0);
    runTransaction(1);
    applyStimulus(1, 5'b11111, 32'd3, 32'd4);
    runTransaction(0);

    // Abort a multiply mid-execution.
    applyStimulus(0, OP_MUL, 32'd6, 32'd7);
    mask = 0;
    while (!alu_enable && mask < 10) begin
      @(negedge clk); mask++;
    end
    checkOutput("clr_exec_reached", 64'(alu_enable), 64'd1);
    clr = 1'b1; req_valid = 2'b00; pend[0] = 1'b0; pend[1] = 1'b0; lg_m = 1'b1;
    @(negedge clk);
    checkOutput("clr_abort", {61'd0, rsp_valid, alu_enable, req_ready != 2'b00}, 64'd0);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_abort_idle", {rsp_lo, 31'd0, rsp_valid}, 64'd0);
    applyStimulus(0, OP_ADD, 32'd1, 32'd1);
    runTransaction(0);

    // Random traffic against the model.
    for (int it = 0; it < 40; it++) begin
      mask = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++) begin
        if (mask[r]) begin
          op = 5'($urandom_range(0, 15));
          if (op > 5'd11) op = 5'($urandom_range(12, 31));
          b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          applyStimulus(r, op, $urandom, b);
        end
      end
      while (pend[0] || pend[1]) runTransaction($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
